// File: rtl/aq_ifu_ipack_buf_ctrl_if.sv
// Fetch-to-decode handshake bundle of the instruction package buffer.
// The buffer controller takes the slave side; fetch/decode (or a bench) drive the master side.
interface aq_ifu_ipack_buf_ctrl_if #(
    parameter int PTR_W = 3
);
    logic             ifu_ipack_vld;
    logic [31:0]      ifu_ipack_data;
    logic [1:0]       ifu_ipack_hw_vld;
    logic             ifu_ipack_acc_err;
    logic             ifu_ipack_pgflt;
    logic             id_ipack_inst_ack;
    logic             ipack_ifu_ready;
    logic             ipack_id_inst_vld;
    logic [31:0]      ipack_id_inst;
    logic             ipack_id_inst_16bit;
    logic             ipack_id_acc_err;
    logic             ipack_id_pgflt;
    logic [PTR_W:0]   ipack_buf_cnt;

    modport master (
        output ifu_ipack_vld, ifu_ipack_data, ifu_ipack_hw_vld,
               ifu_ipack_acc_err, ifu_ipack_pgflt, id_ipack_inst_ack,
        input  ipack_ifu_ready, ipack_id_inst_vld, ipack_id_inst,
               ipack_id_inst_16bit, ipack_id_acc_err, ipack_id_pgflt, ipack_buf_cnt
    );

    modport slave (
        input  ifu_ipack_vld, ifu_ipack_data, ifu_ipack_hw_vld,
               ifu_ipack_acc_err, ifu_ipack_pgflt, id_ipack_inst_ack,
        output ipack_ifu_ready, ipack_id_inst_vld, ipack_id_inst,
               ipack_id_inst_16bit, ipack_id_acc_err, ipack_id_pgflt, ipack_buf_cnt
    );
endinterface

// File: rtl/aq_ifu_ipack_buf_ctrl.sv
// Circular halfword buffer packing fetch data into 16/32-bit instructions for decode.
// Latency: a written halfword is presentable the cycle after the push (no bypass).
// Backpressure: ready drops when fewer than two entries are free; pushes while not ready are dropped.
module aq_ifu_ipack_buf_ctrl #(
    parameter int ENTRY_NUM = 8,
    parameter int PTR_W     = 3
) (
    input  logic                          ipack_cpuclk,
    input  logic                          cpurst_b,
    input  logic                          ipack_buf_flush,
    aq_ifu_ipack_buf_ctrl_if.slave        ipack
);

    localparam logic [PTR_W:0] CNT_READY_MAX = (PTR_W+1)'(ENTRY_NUM - 2);

    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [PTR_W:0]       cnt;
    logic [15:0]          ent_inst    [ENTRY_NUM];
    logic [ENTRY_NUM-1:0] ent_acc_err;
    logic [ENTRY_NUM-1:0] ent_pgflt;
    logic [ENTRY_NUM-1:0] ent_we;

    logic                 ready;
    logic                 push_en;
    logic                 both_hw;
    logic [1:0]           push_sz;
    logic [PTR_W-1:0]     wptr_p1;
    logic [PTR_W-1:0]     rptr_p1;

    assign ready   = (cnt <= CNT_READY_MAX);
    assign push_en = ipack.ifu_ipack_vld & ready & ~ipack_buf_flush;
    assign both_hw = (ipack.ifu_ipack_hw_vld == 2'b11);
    assign push_sz = push_en ? (both_hw ? 2'd2 : 2'd1) : 2'd0;
    assign wptr_p1 = wptr + 1'b1;
    assign rptr_p1 = rptr + 1'b1;

    // Per-entry enables are pure functions of the push, so they can drive clock gates directly.
    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_ent
        logic        hit_lo;
        logic        hit_hi;
        logic [15:0] wdat;

        assign hit_lo = (wptr == PTR_W'(i));
        assign hit_hi = both_hw & (wptr_p1 == PTR_W'(i));
        assign ent_we[i] = push_en & (hit_lo | hit_hi);
        assign wdat = (hit_hi || ipack.ifu_ipack_hw_vld == 2'b10) ? ipack.ifu_ipack_data[31:16]
                                                                   : ipack.ifu_ipack_data[15:0];

        always_ff @(posedge ipack_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                ent_inst[i]    <= 16'h0;
                ent_acc_err[i] <= 1'b0;
                ent_pgflt[i]   <= 1'b0;
            end else if (ent_we[i]) begin
                ent_inst[i]    <= wdat;
                ent_acc_err[i] <= ipack.ifu_ipack_acc_err;
                ent_pgflt[i]   <= ipack.ifu_ipack_pgflt;
            end
        end
    end

    logic [15:0] h_inst;
    logic [15:0] n_inst;
    logic        h_fault;
    logic        inst_vld;
    logic [31:0] inst;
    logic        inst_16bit;
    logic        acc_err;
    logic        pgflt;
    logic [1:0]  pop_len;
    logic [1:0]  pop_sz;

    assign h_inst  = ent_inst[rptr];
    assign n_inst  = ent_inst[rptr_p1];
    assign h_fault = ent_acc_err[rptr] | ent_pgflt[rptr];

    // A faulted head is always issued alone so decode sees the fault on the first halfword.
    always_comb begin
        inst_vld   = 1'b0;
        inst       = 32'h0;
        inst_16bit = 1'b0;
        acc_err    = 1'b0;
        pgflt      = 1'b0;
        pop_len    = 2'd0;
        if (cnt != '0) begin
            if (h_fault || h_inst[1:0] != 2'b11) begin
                inst_vld   = 1'b1;
                inst       = {16'h0, h_inst};
                inst_16bit = 1'b1;
                acc_err    = ent_acc_err[rptr];
                pgflt      = ent_pgflt[rptr];
                pop_len    = 2'd1;
            end else if (cnt >= (PTR_W+1)'(2)) begin
                inst_vld   = 1'b1;
                inst       = {n_inst, h_inst};
                acc_err    = ent_acc_err[rptr_p1];
                pgflt      = ent_pgflt[rptr_p1];
                pop_len    = 2'd2;
            end
        end
    end

    assign pop_sz = (inst_vld & ipack.id_ipack_inst_ack) ? pop_len : 2'd0;

    always_ff @(posedge ipack_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (ipack_buf_flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            wptr <= wptr + PTR_W'(push_sz);
            rptr <= rptr + PTR_W'(pop_sz);
            cnt  <= cnt + (PTR_W+1)'(push_sz) - (PTR_W+1)'(pop_sz);
        end
    end

    assign ipack.ipack_ifu_ready     = ready;
    assign ipack.ipack_id_inst_vld   = inst_vld;
    assign ipack.ipack_id_inst       = inst;
    assign ipack.ipack_id_inst_16bit = inst_16bit;
    assign ipack.ipack_id_acc_err    = acc_err;
    assign ipack.ipack_id_pgflt      = pgflt;
    assign ipack.ipack_buf_cnt       = cnt;

endmodule

// File: tb/tb_aq_ifu_ipack_buf_ctrl.sv
// Directed bench for the instruction package buffer: packing, faults, full/wrap, flush and reset.
module tb_aq_ifu_ipack_buf_ctrl;

    logic clk;
    logic rst_b;
    logic flush;
    int   n_chk;
    int   n_fail;

    aq_ifu_ipack_buf_ctrl_if #(.PTR_W(3)) ipk ();

    aq_ifu_ipack_buf_ctrl #(.ENTRY_NUM(8), .PTR_W(3)) dut (
        .ipack_cpuclk    (clk),
        .cpurst_b        (rst_b),
        .ipack_buf_flush (flush),
        .ipack           (ipk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clr_in();
        ipk.ifu_ipack_vld     = 1'b0;
        ipk.ifu_ipack_data    = 32'h0;
        ipk.ifu_ipack_hw_vld  = 2'b00;
        ipk.ifu_ipack_acc_err = 1'b0;
        ipk.ifu_ipack_pgflt   = 1'b0;
        ipk.id_ipack_inst_ack = 1'b0;
        flush                 = 1'b0;
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [31:0] d, input logic [1:0] m,
                       input logic ae, input logic pf, input logic ack, input logic fl);
        ipk.ifu_ipack_vld     = v;
        ipk.ifu_ipack_data    = d;
        ipk.ifu_ipack_hw_vld  = m;
        ipk.ifu_ipack_acc_err = ae;
        ipk.ifu_ipack_pgflt   = pf;
        ipk.id_ipack_inst_ack = ack;
        flush                 = fl;
        @(posedge clk);
        #1;
        clr_in();
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] m);
        cyc(1'b1, d, m, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_all_idle(input string tag);
        chk({tag, "_vld"},   32'(ipk.ipack_id_inst_vld),   32'h0);
        chk({tag, "_inst"},  ipk.ipack_id_inst,            32'h0);
        chk({tag, "_16b"},   32'(ipk.ipack_id_inst_16bit), 32'h0);
        chk({tag, "_ae"},    32'(ipk.ipack_id_acc_err),    32'h0);
        chk({tag, "_pf"},    32'(ipk.ipack_id_pgflt),      32'h0);
        chk({tag, "_cnt"},   32'(ipk.ipack_buf_cnt),       32'h0);
        chk({tag, "_rdy"},   32'(ipk.ipack_ifu_ready),     32'h1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clr_in();
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_idle("rst");
        rst_b = 1'b1;

        // Two 16-bit instructions in one push
        push(32'h4501_0001, 2'b11);
        chk("p1_cnt",  32'(ipk.ipack_buf_cnt),       32'd2);
        chk("p1_vld",  32'(ipk.ipack_id_inst_vld),   32'h1);
        chk("p1_inst", ipk.ipack_id_inst,            32'h0000_0001);
        chk("p1_16b",  32'(ipk.ipack_id_inst_16bit), 32'h1);
        ack();
        chk("p1a_cnt",  32'(ipk.ipack_buf_cnt), 32'd1);
        chk("p1a_inst", ipk.ipack_id_inst,      32'h0000_4501);
        ack();
        chk("p1b_cnt",  32'(ipk.ipack_buf_cnt),     32'd0);
        chk("p1b_vld",  32'(ipk.ipack_id_inst_vld), 32'h0);

        // One 32-bit instruction popped as a pair
        push(32'h0000_0513, 2'b11);
        chk("p2_inst", ipk.ipack_id_inst,            32'h0000_0513);
        chk("p2_16b",  32'(ipk.ipack_id_inst_16bit), 32'h0);
        chk("p2_vld",  32'(ipk.ipack_id_inst_vld),   32'h1);
        ack();
        chk("p2a_cnt", 32'(ipk.ipack_buf_cnt),     32'd0);
        chk("p2a_vld", 32'(ipk.ipack_id_inst_vld), 32'h0);
        push(32'h1234_5678, 2'b11);
        chk("p2b_cnt",  32'(ipk.ipack_buf_cnt), 32'd2);
        chk("p2b_inst", ipk.ipack_id_inst,      32'h0000_5678);
        ack();
        chk("p2c_inst", ipk.ipack_id_inst,      32'h0000_1234);
        ack();
        chk("p2c_cnt",  32'(ipk.ipack_buf_cnt), 32'd0);

        // 32-bit instruction split across two pushes
        push(32'h0513_abcd, 2'b10);
        chk("p3_vld", 32'(ipk.ipack_id_inst_vld), 32'h0);
        chk("p3_cnt", 32'(ipk.ipack_buf_cnt),     32'd1);
        push(32'h9999_0000, 2'b01);
        chk("p3b_vld",  32'(ipk.ipack_id_inst_vld),   32'h1);
        chk("p3b_inst", ipk.ipack_id_inst,            32'h0000_0513);
        chk("p3b_16b",  32'(ipk.ipack_id_inst_16bit), 32'h0);
        ack();
        chk("p3c_cnt", 32'(ipk.ipack_buf_cnt), 32'd0);

        // Fill to 7 entries; pointers now sit at 0
        push(32'h0021_0011, 2'b11);
        push(32'h0041_0031, 2'b11);
        push(32'h0061_0051, 2'b11);
        chk("f6_cnt", 32'(ipk.ipack_buf_cnt),   32'd6);
        chk("f6_rdy", 32'(ipk.ipack_ifu_ready), 32'h1);
        push(32'hffff_0071, 2'b01);
        chk("f7_cnt", 32'(ipk.ipack_buf_cnt),   32'd7);
        chk("f7_rdy", 32'(ipk.ipack_ifu_ready), 32'h0);
        push(32'h0091_0081, 2'b11);
        chk("drop_cnt",  32'(ipk.ipack_buf_cnt), 32'd7);
        chk("drop_inst", ipk.ipack_id_inst,      32'h0000_0011);
        // Push alongside pop while full: push must still be dropped
        cyc(1'b1, 32'h0091_0081, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("fp_cnt",  32'(ipk.ipack_buf_cnt),   32'd6);
        chk("fp_rdy",  32'(ipk.ipack_ifu_ready), 32'h1);
        chk("fp_inst", ipk.ipack_id_inst,        32'h0000_0021);

        // Streaming push/pop across the pointer wrap; head walks 0x31, 0x41, ...
        for (int k = 0; k < 10; k++) begin
            logic [15:0] pv;
            pv = 16'h0081 + 16'(k * 16);
            cyc(1'b1, {16'hffff, pv}, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("wrap%0d_inst", k), ipk.ipack_id_inst, 32'(16'h0031 + 16'(k * 16)));
            chk($sformatf("wrap%0d_cnt", k),  32'(ipk.ipack_buf_cnt), 32'd6);
        end

        cyc(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fl1_cnt", 32'(ipk.ipack_buf_cnt),     32'd0);
        chk("fl1_vld", 32'(ipk.ipack_id_inst_vld), 32'h0);

        // Page fault on the upper half of a 32-bit instruction
        push(32'hffff_0513, 2'b01);
        cyc(1'b1, 32'hffff_1234, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pf_vld",  32'(ipk.ipack_id_inst_vld),   32'h1);
        chk("pf_inst", ipk.ipack_id_inst,            32'h1234_0513);
        chk("pf_16b",  32'(ipk.ipack_id_inst_16bit), 32'h0);
        chk("pf_pf",   32'(ipk.ipack_id_pgflt),      32'h1);
        chk("pf_ae",   32'(ipk.ipack_id_acc_err),    32'h0);
        ack();
        chk("pf_cnt", 32'(ipk.ipack_buf_cnt), 32'd0);

        // Access-faulted head with 32-bit opcode bits is issued as a single halfword
        cyc(1'b1, 32'h5555_0013, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ae_inst", ipk.ipack_id_inst,            32'h0000_0013);
        chk("ae_16b",  32'(ipk.ipack_id_inst_16bit), 32'h1);
        chk("ae_ae",   32'(ipk.ipack_id_acc_err),    32'h1);
        ack();
        chk("ae_cnt",   32'(ipk.ipack_buf_cnt), 32'd1);
        chk("ae2_inst", ipk.ipack_id_inst,      32'h0000_5555);
        chk("ae2_ae",   32'(ipk.ipack_id_acc_err), 32'h1);
        ack();

        // Flush wins over a simultaneous push and ack
        push(32'h0021_0011, 2'b11);
        push(32'h0041_0031, 2'b11);
        chk("f4_cnt", 32'(ipk.ipack_buf_cnt), 32'd4);
        cyc(1'b1, 32'h0061_0051, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("fl2_cnt", 32'(ipk.ipack_buf_cnt),     32'd0);
        chk("fl2_vld", 32'(ipk.ipack_id_inst_vld), 32'h0);
        chk("fl2_rdy", 32'(ipk.ipack_ifu_ready),   32'h1);

        // Asynchronous reset mid-stream
        push(32'h0000_0513, 2'b11);
        chk("pre_rst_cnt", 32'(ipk.ipack_buf_cnt), 32'd2);
        #2;
        rst_b = 1'b0;
        #1;
        chk_all_idle("arst");
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        push(32'h4501_0001, 2'b11);
        chk("post_rst_inst", ipk.ipack_id_inst,      32'h0000_0001);
        chk("post_rst_cnt",  32'(ipk.ipack_buf_cnt), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
